// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin IF/D arbiter for one single-port memory (optional watchdog: ARB_TIMEOUT_EN)
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ready,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    output logic            err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    logic [1:0]      state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW/8-1:0] mem_be_q, mem_be_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            if_ready_q, if_ready_d;
    logic            d_ready_q, d_ready_d;
    logic            pick;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    assign err = err_q;
`else
    // TIMEOUT has no effect without the watchdog.
    localparam int UNUSED_TIMEOUT = TIMEOUT;
    assign err = 1'b0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;

    // Round-robin choice: on contention the requester not served last wins.
    always_comb begin
        if (if_req && d_req) begin
            pick = (last_q == OWN_IF) ? OWN_D : OWN_IF;
        end else if (if_req) begin
            pick = OWN_IF;
        end else begin
            pick = OWN_D;
        end
    end

    // Next-state and registered-output logic for the IDLE/ISSUE/RESP sequence.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    owner_d   = pick;
                    last_d    = pick;
                    mem_req_d = 1'b1;
                    state_d   = ST_ISSUE;
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                    if (pick == OWN_IF) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = '1;
                    end else begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_we ? d_be : '1;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = mem_rdata;
                        d_ready_d = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                // Abort after TIMEOUT ISSUE cycles: complete with zero data and err.
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                    err_d     = 1'b1;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = '0;
                        if_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = '0;
                        d_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops everything, losing any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            last_q      <= OWN_D;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog counter and error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ack = 1'b0;

        // Reset state
        step; step;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_if_ready", {31'b0, if_ready}, 32'd0);
        check("rst_d_ready", {31'b0, d_ready}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", {28'b0, mem_be}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b1;
        step; step;
        check("idle_no_req", {31'b0, mem_req}, 32'd0);

        // IF fetch, zero-wait memory
        if_req = 1'b1; if_addr = 32'h0000_0004; mem_rdata = 32'h0040_0093; mem_ack = 1'b1;
        step;
        check("if_mem_req", {31'b0, mem_req}, 32'd1);
        check("if_mem_addr", mem_addr, 32'h4);
        check("if_mem_we", {31'b0, mem_we}, 32'd0);
        check("if_mem_be", {28'b0, mem_be}, 32'hF);
        check("if_ready_c1", {31'b0, if_ready}, 32'd0);
        step;
        check("if_ready_c2", {31'b0, if_ready}, 32'd1);
        check("if_rdata", if_rdata, 32'h0040_0093);
        check("if_mem_req_drop", {31'b0, mem_req}, 32'd0);
        check("if_d_ready", {31'b0, d_ready}, 32'd0);
        if_req = 1'b0; mem_ack = 1'b0;
        step;
        check("if_ready_c3", {31'b0, if_ready}, 32'd0);

        // D store with three wait cycles
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D; d_be = 4'b0011;
        mem_rdata = 32'h1234_5678;
        step;
        for (int w = 0; w < 3; w++) begin
            check("st_mem_req", {31'b0, mem_req}, 32'd1);
            check("st_mem_addr", mem_addr, 32'h100);
            check("st_mem_we", {31'b0, mem_we}, 32'd1);
            check("st_mem_wdata", mem_wdata, 32'hCAFE_F00D);
            check("st_mem_be", {28'b0, mem_be}, 32'h3);
            check("st_d_ready_wait", {31'b0, d_ready}, 32'd0);
            step;
        end
        check("st_mem_req_last", {31'b0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        step;
        check("st_d_ready", {31'b0, d_ready}, 32'd1);
        check("st_if_ready", {31'b0, if_ready}, 32'd0);
        check("st_mem_req_drop", {31'b0, mem_req}, 32'd0);
        check("st_err", {31'b0, err}, 32'd0);
        mem_ack = 1'b0; d_req = 1'b0;
        step;
        check("st_d_ready_off", {31'b0, d_ready}, 32'd0);

        // Contention after reset: IF, D, IF, D
        rst = 1'b0; #2; rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'b0101;
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic exp_if;
            exp_if = (k % 2 == 0);
            mem_rdata = 32'hA000_0000 + k;
            step;
            check("rr_mem_req", {31'b0, mem_req}, 32'd1);
            check("rr_mem_addr", mem_addr, exp_if ? 32'h8 : 32'h200);
            check("rr_mem_be", {28'b0, mem_be}, 32'hF);
            step;
            check("rr_if_ready", {31'b0, if_ready}, {31'b0, exp_if});
            check("rr_d_ready", {31'b0, d_ready}, {31'b0, !exp_if});
            if (exp_if) check("rr_if_rdata", if_rdata, 32'hA000_0000 + k);
            else        check("rr_d_rdata", d_rdata, 32'hA000_0000 + k);
            step;
            check("rr_resp_no_grant", {31'b0, mem_req}, 32'd0);
            check("rr_ready_pulse", {30'b0, if_ready, d_ready}, 32'd0);
        end
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        step;

        // Reset while waiting for ack
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        step;
        check("mr_mem_req", {31'b0, mem_req}, 32'd1);
        step;
        check("mr_mem_req_wait", {31'b0, mem_req}, 32'd1);
        #2; rst = 1'b0; #1;
        check("mr_async_drop", {31'b0, mem_req}, 32'd0);
        check("mr_async_ready", {31'b0, d_ready}, 32'd0);
        d_req = 1'b0;
        step;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step;
            check("mr_after_ready", {31'b0, d_ready}, 32'd0);
            check("mr_after_req", {31'b0, mem_req}, 32'd0);
        end

`ifdef ARB_TIMEOUT_EN
        // Watchdog abort with mem_ack held low
        begin
            int  hi;
            bit  seen;
            hi = 0; seen = 1'b0;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; mem_ack = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                step;
                if (mem_req) hi++;
                if (!d_ready) check("to_err_idle", {31'b0, err}, 32'd0);
                if (d_ready) begin
                    seen = 1'b1;
                    check("to_err", {31'b0, err}, 32'd1);
                    check("to_rdata", d_rdata, 32'd0);
                    check("to_mem_req", {31'b0, mem_req}, 32'd0);
                end
            end
            check("to_seen", {31'b0, seen}, 32'd1);
            check("to_req_cycles", hi, 32'd16);
            d_req = 1'b0;
            step;
            check("to_err_off", {31'b0, err}, 32'd0);
            if_req = 1'b1; if_addr = 32'hC; mem_rdata = 32'h0000_0013; mem_ack = 1'b1;
            step;
            check("to_if_addr", mem_addr, 32'hC);
            step;
            check("to_if_ready", {31'b0, if_ready}, 32'd1);
            check("to_if_rdata", if_rdata, 32'h13);
            check("to_if_err", {31'b0, err}, 32'd0);
            if_req = 1'b0; mem_ack = 1'b0;
            step;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got=running expected=finished");
        $fatal(1);
    end

endmodule
